// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO fed by single-cycle write pulses, drained as 8N1 UART frames
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_pulse,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_next;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [BW-1:0] baud;
  logic push, pop, tick;
  assign push = wr_pulse & ~full;
  assign pop = (state == IDLE) & ~empty;
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // storage array carries no reset; only pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;
  // FIFO pointers, occupancy and the flags derived from next occupancy
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_next;
      empty <= count_next == '0;
      full <= count_next == (AW+1)'(DEPTH);
      overflow <= wr_pulse & full;
    end
  // next-state logic: each non-idle state advances on the last clock of its bit period
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = pop ? START : IDLE;
      START:   state_next = tick ? DATA : START;
      DATA:    state_next = (tick && bit_idx == 3'd7) ? STOP : DATA;
      default: state_next = tick ? IDLE : STOP;
    endcase
  end
  // serializer state, baud timing and registered line outputs (one clock behind state)
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_next;
      baud <= (state == IDLE || tick) ? '0 : baud + 1'b1;
      if (pop) shift <= mem[rptr];
      else if (state == DATA && tick) shift <= shift >> 1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
      tx <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      busy <= state != IDLE;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of FIFO buffering, 8N1 framing, overflow and reset
module tb_uart_tx_fifo;
  localparam int C = 10;
  logic clk, reset, wr_pulse, tx, busy, empty, full, overflow;
  logic [7:0] wr_data;
  int tests, fails, cyc, busy_cnt, ovf_cnt, rst_cnt, frame_err;
  logic [7:0] rx[$];
  int starts[$];
  logic [7:0] rxb;
  logic ok;
  int r0;

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_pulse(wr_pulse), .wr_data(wr_data),
    .tx(tx), .busy(busy), .empty(empty), .full(full), .overflow(overflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (overflow) ovf_cnt++;
  end

  always @(negedge reset) rst_cnt++;

  // reference UART receiver sampling mid-bit; frames cut by reset are discarded
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        r0 = rst_cnt;
        ok = 1;
        repeat (C/2) @(negedge clk);
        if (tx !== 1'b0) ok = 0;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          rxb[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (tx !== 1'b1) ok = 0;
        if (rst_cnt == r0) begin
          if (ok) rx.push_back(rxb);
          else frame_err++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_pulse = 1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_pulse = 0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget && rx.size() < n; k++) @(negedge clk);
    chk("rx_count", rx.size(), n);
  endtask

  task automatic chk_rx(input int i, input logic [7:0] exp);
    chk("rx_data", (rx.size() > i) ? {24'd0, rx[i]} : 32'hDEAD, {24'd0, exp});
  endtask

  initial begin
    int b0;
    tests = 0; fails = 0; cyc = 0; busy_cnt = 0; ovf_cnt = 0; rst_cnt = 0; frame_err = 0;
    wr_pulse = 0; wr_data = 0; reset = 0;
    #23;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    step(1);
    reset = 1;
    step(2);

    // single 0xA5 frame with exact latency and busy width
    rx.delete();
    b0 = busy_cnt;
    wr(8'hA5);
    chk("t1_empty_after_push", empty, 0);
    step(1);
    chk("t1_tx_pop_edge", tx, 1);
    chk("t1_empty_after_pop", empty, 1);
    step(1);
    chk("t1_tx_start", tx, 0);
    chk("t1_busy", busy, 1);
    wait_rx(1, 200);
    chk_rx(0, 8'hA5);
    step(20);
    chk("t1_busy_clks", busy_cnt - b0, 100);

    // three back-to-back bytes: one idle cycle between frames
    rx.delete();
    starts.delete();
    wr(8'h01); wr(8'h02); wr(8'h03);
    chk("t2_count_peak", dut.count, 2);
    wait_rx(3, 500);
    chk_rx(0, 8'h01); chk_rx(1, 8'h02); chk_rx(2, 8'h03);
    chk("t2_gap01", (starts.size() > 1) ? starts[1] - starts[0] : 0, 10*C + 1);
    chk("t2_gap12", (starts.size() > 2) ? starts[2] - starts[1] : 0, 10*C + 1);
    step(20);

    // ten writes into an idle FIFO: nine accepted, one dropped
    rx.delete();
    b0 = ovf_cnt;
    for (int i = 0; i < 10; i++) begin
      wr(8'h10 + 8'(i));
      if (i == 8) chk("t3_full", full, 1);
      if (i == 9) chk("t3_ovf_pulse", overflow, 1);
    end
    step(1);
    chk("t3_ovf_clear", overflow, 0);
    wait_rx(9, 9*101 + 100);
    for (int i = 0; i < 9; i++) chk_rx(i, 8'h10 + 8'(i));
    chk("t3_ovf_count", ovf_cnt - b0, 1);
    step(20);

    // write exactly on the pop edge while full: dropped, count falls to 7
    rx.delete();
    b0 = ovf_cnt;
    for (int i = 0; i < 9; i++) wr(8'h40 + 8'(i));
    step(93);
    chk("t4_full_before", full, 1);
    wr(8'hEE);
    chk("t4_ovf", overflow, 1);
    chk("t4_full_after", full, 0);
    chk("t4_count", dut.count, 7);
    wait_rx(9, 9*101 + 200);
    for (int i = 0; i < 9; i++) chk_rx(i, 8'h40 + 8'(i));
    chk("t4_ovf_count", ovf_cnt - b0, 1);
    step(20);

    // reset during DATA of 0x3C with two bytes queued
    rx.delete();
    wr(8'h3C); wr(8'h11); wr(8'h22);
    step(40);
    #3 reset = 0;
    #1;
    chk("t5_tx", tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_empty", empty, 1);
    step(3);
    reset = 1;
    step(400);
    chk("t5_no_frames", rx.size(), 0);
    chk("t5_tx_idle", tx, 1);

    // twenty spaced writes exercise pointer wrap
    rx.delete();
    b0 = ovf_cnt;
    for (int i = 0; i < 20; i++) begin
      wr(8'(i*37 + 5));
      step(105);
    end
    wait_rx(20, 300);
    for (int i = 0; i < 20; i++) chk_rx(i, 8'(i*37 + 5));
    chk("t6_no_ovf", ovf_cnt - b0, 0);
    chk("frame_errors", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Downstream consumer of the single-cycle write pulse generator. It accepts a byte on each one-clock write pulse, buffers it in a small FIFO, and serializes it as 8N1 UART frames on the robot command link. The block decouples bursty command writes from the slow serial line and flags any bytes lost to overflow.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
DEPTH, 8, FIFO depth in bytes; must be a power of two, >= 2
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, derived), clocks per serial bit; must be >= 2

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wr_pulse  in  1  single-cycle write strike; one byte pushed per high cycle
wr_data  in  8  byte sampled on the edge where wr_pulse=1
tx  out  1  serial line, idle high
busy  out  1  high while a frame is being shifted (states START/DATA/STOP)
empty  out  1  FIFO holds zero bytes
full  out  1  FIFO holds DEPTH bytes
overflow  out  1  one-cycle pulse when a write is dropped because FIFO full

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers and count=0, FSM=IDLE, bit counter=0, baud counter=0, tx=1, busy=0, empty=1, full=0, overflow=0.
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0; count register 0..DEPTH. empty=(count==0), full=(count==DEPTH), both registered from count.
- Push: on an edge with wr_pulse=1 and full=0, store wr_data at wptr, wptr+1. With wr_pulse=1 and full=1: data dropped, pointers unchanged, overflow=1 on the next cycle only. Push accept is decided by full at that edge, even if a pop happens at the same edge.
- Pop: only in IDLE with empty=0: shift register <= mem[rptr], rptr+1, FSM -> START. Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states:
  IDLE: tx=1, busy=0. Pop as above.
  START: tx=0 for CLKS_PER_BIT clocks, then -> DATA with bit index 0.
  DATA: tx=shift[0], LSB first. After each CLKS_PER_BIT clocks shift right; after bit 7 -> STOP.
  STOP: tx=1 for CLKS_PER_BIT clocks, then -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on each state or bit change. It does not run in IDLE.
- Latency: wr_pulse at edge N into an empty FIFO with FSM idle -> empty=0 after N; pop at N+1; tx=0 from N+2. Frame length is exactly 10*CLKS_PER_BIT clocks.
- Back-to-back: if the FIFO is non-empty when STOP ends, there is exactly one IDLE cycle (tx=1) before the next start bit.
- tx, busy, empty, full, overflow are all registered outputs; tx is glitch-free.
- Reset mid-frame: tx returns to 1 immediately and the FIFO contents are discarded.
- wr_pulse held high for multiple cycles pushes one byte per cycle. Shaping the pulse is the upstream pulse generator's job.

Test Plan:
- Use CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10). Single write of 0xA5 -> tx: start 0 for 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, stop 1; busy high for exactly 100 clks; empty returns to 1 after pop.
- Three consecutive wr_pulse cycles with 0x01, 0x02, 0x03 -> three frames in order, each separated by exactly one idle-high cycle; count peaks at 2 after the first pop.
- Fill beyond capacity: 10 writes on consecutive cycles with DEPTH=8, FSM idle at start -> first byte popped on the 2nd cycle, so 9 accepted and 1 dropped; overflow pulses once; full=1; the 9 frames carry the accepted data in order.
- Write at the edge where the FIFO is full and STOP->IDLE pops -> write dropped, overflow=1, count=DEPTH-1 afterwards.
- Assert reset in the middle of the DATA state of byte 0x3C with 2 bytes queued -> tx=1, busy=0, empty=1 immediately; after release, no further frames appear.
- Pointer wrap: 20 writes spaced one frame apart -> all 20 bytes are transmitted correctly through rptr/wptr wrap-around, and overflow is never asserted.
